mult_seq: RTL and testbench
===========================

Name: mult_seq

Overview:
- Multi-cycle unsigned shift-add multiplier controller for the processor execute stage.
- Sequences one shared WIDTH-bit carry-lookahead adder, built from 4-bit CLA slices, over WIDTH iterations.
- Produces a 2*WIDTH-bit product.
- Uses a start/busy/done handshake so the pipeline stalls on busy and captures the product on done.

Parameters:
- WIDTH, 16, operand width. Must be a multiple of 4, because the adder is composed of 4-bit CLA slices.
- CNTW, 4, iteration counter width. Must satisfy 2**CNTW >= WIDTH.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only when the state is IDLE or DONE.
- a  input  WIDTH  multiplicand; captured on an accepted start.
- b  input  WIDTH  multiplier; captured on an accepted start.
- busy  output  1  high while the state is RUN.
- done  output  1  one-cycle pulse when the product is valid; high only in state DONE.
- product  output  2*WIDTH  registered result; holds its value until the next completion.

Behaviour:
- Reset: one clock with rst=1 gives state=IDLE, busy=0, done=0, product=0, and all internal registers (acc, mq, mcand, cnt) =0. Reset wins over every other input, including a reset asserted mid-RUN; the operation in flight is discarded and done is never pulsed for it.
- States: IDLE, RUN, DONE. busy and done decode directly from state (registered, no combinational path from start).
- IDLE or DONE with start=1 at edge E:
  - acc<=0, mq<=b, mcand<=a, cnt<=0, state<=RUN.
  - From DONE this back-to-back start is legal; done is high for exactly that one cycle.
- IDLE or DONE with start=0: state<=IDLE.
- RUN, each edge performs one iteration:
  - If mq[0]=1: {c,s}=acc+mcand with cin=0 through the CLA adder; {acc,mq}<={c,s,mq[WIDTH-1:1]}.
  - If mq[0]=0: {acc,mq}<={1'b0,acc,mq[WIDTH-1:1]}.
  - cnt<=cnt+1.
- RUN, iteration when cnt==WIDTH-1: also product<={acc_next,mq_next} and state<=DONE.
- start is ignored while in RUN. There is no queueing, and a, b may change freely during RUN.
- Latency is fixed: start accepted at edge E, iterations at edges E+1..E+WIDTH, done high in the cycle after edge E+WIDTH.
  - busy is high for exactly WIDTH cycles.
  - There is no early termination for zero operands.
- Arithmetic:
  - Adder carry-out is the shift-in bit, so there is no overflow loss.
  - The maximum product (2**WIDTH-1)**2 fits in 2*WIDTH bits.
- product updates only on the completing edge. It is stable during RUN and holds the previous result.
- cnt wraps only through reload at start. It never exceeds WIDTH-1 in RUN.

Decomposition:
- Shared header mult_defs.vh holds:
  - state encodings ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2;
  - the default WIDTH.
- One sub-module, cla_n: a WIDTH-bit adder made of WIDTH/4 chained 4-bit CLA slices. It has ports A, B, Cin, S, Cout and is purely combinational.
- mult_seq owns the FSM, counter and shift registers, and instantiates cla_n once.

Test Plan:
- Reset, then a=3, b=5, start for 1 cycle -> busy high 16 cycles, then done=1 for 1 cycle with product=32'h0000000F; busy=0 afterwards.
- a=16'hFFFF, b=16'hFFFF -> product=32'hFFFE0001. Carry-out shift-in is exercised.
- b=0, a=16'h1234 -> still 16 busy cycles; product=0. Then a=0, b=16'h8000 -> product=0.
- a=7, b=9, start accepted; start pulsed again at RUN cycle 5 with a=2, b=2 -> ignored; product=63, single done pulse.
- start held high continuously with a=10, b=10 -> a new operation begins in the done cycle; done pulses every 17 cycles, each with product=100.
- rst=1 at RUN cycle 8 of a=100, b=200 -> next cycle busy=0, done=0, product=0, state IDLE. A following start with a=2, b=3 gives product=6.

Source files
------------

// File: rtl/mult_seq_pkg.sv
// Shared definitions for the sequential shift-add multiplier.
package mult_seq_pkg;

    localparam int MULT_WIDTH = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/mult_seq_cla_n.sv
// WIDTH-bit adder built from chained 4-bit carry-lookahead slices.
module cla_n #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic [WIDTH-1:0] S,
    output logic             Cout
);

    localparam int N = WIDTH / 4;

    logic [N:0] w_c;

    assign w_c[0] = Cin;
    assign Cout   = w_c[N];

    for (genvar i = 0; i < N; i++) begin : g_slice
        logic [3:0] w_p;
        logic [3:0] w_g;
        logic [4:0] w_cc;

        assign w_p = A[4*i +: 4] ^ B[4*i +: 4];
        assign w_g = A[4*i +: 4] & B[4*i +: 4];

        assign w_cc[0] = w_c[i];
        assign w_cc[1] = w_g[0]
                       | (w_p[0] & w_cc[0]);
        assign w_cc[2] = w_g[1]
                       | (w_p[1] & w_g[0])
                       | (w_p[1] & w_p[0] & w_cc[0]);
        assign w_cc[3] = w_g[2]
                       | (w_p[2] & w_g[1])
                       | (w_p[2] & w_p[1] & w_g[0])
                       | (w_p[2] & w_p[1] & w_p[0] & w_cc[0]);
        assign w_cc[4] = w_g[3]
                       | (w_p[3] & w_g[2])
                       | (w_p[3] & w_p[2] & w_g[1])
                       | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                       | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & w_cc[0]);

        assign S[4*i +: 4] = w_p ^ w_cc[3:0];
        assign w_c[i+1]    = w_cc[4];
    end

endmodule

// File: rtl/mult_seq.sv
// Multi-cycle unsigned shift-add multiplier with start/busy/done handshake.
import mult_seq_pkg::*;

module mult_seq #(
    parameter int WIDTH = MULT_WIDTH,
    parameter int CNTW  = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    localparam logic [CNTW-1:0] LAST = CNTW'(WIDTH - 1);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [WIDTH-1:0]   r_acc;
    logic [WIDTH-1:0]   r_mq;
    logic [WIDTH-1:0]   r_mcand;
    logic [CNTW-1:0]    r_cnt;
    logic [2*WIDTH-1:0] r_product;

    logic               w_load;
    logic               w_step;
    logic               w_last;
    logic [WIDTH-1:0]   w_sum;
    logic               w_cout;
    logic [WIDTH-1:0]   w_acc_nxt;
    logic [WIDTH-1:0]   w_mq_nxt;

    cla_n #(.WIDTH(WIDTH)) u_cla (
        .A    (r_acc),
        .B    (r_mcand),
        .Cin  (1'b0),
        .S    (w_sum),
        .Cout (w_cout)
    );

    // Adder carry-out becomes the shift-in bit, so nothing is lost.
    always_comb begin
        w_acc_nxt = {1'b0, r_acc[WIDTH-1:1]};
        w_mq_nxt  = {r_acc[0], r_mq[WIDTH-1:1]};
        if (r_mq[0]) begin
            w_acc_nxt = {w_cout, w_sum[WIDTH-1:1]};
            w_mq_nxt  = {w_sum[0], r_mq[WIDTH-1:1]};
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_step      = 1'b0;
        w_last      = 1'b0;
        unique case (r_state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    w_state_nxt = ST_RUN;
                    w_load      = 1'b1;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_RUN: begin
                w_step = 1'b1;
                if (r_cnt == LAST) begin
                    w_last      = 1'b1;
                    w_state_nxt = ST_DONE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc     <= '0;
            r_mq      <= '0;
            r_mcand   <= '0;
            r_cnt     <= '0;
            r_product <= '0;
        end else if (w_load) begin
            r_acc   <= '0;
            r_mq    <= b;
            r_mcand <= a;
            r_cnt   <= '0;
        end else if (w_step) begin
            r_acc <= w_acc_nxt;
            r_mq  <= w_mq_nxt;
            r_cnt <= r_cnt + CNTW'(1);
            if (w_last) begin
                r_product <= {w_acc_nxt, w_mq_nxt};
            end
        end
    end

    assign busy    = (r_state == ST_RUN);
    assign done    = (r_state == ST_DONE);
    assign product = r_product;

endmodule

// File: tb/tb_mult_seq.sv
// Directed-vector bench for mult_seq.
module tb_mult_seq;

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] a;
    logic [15:0] b;
    logic        busy;
    logic        done;
    logic [31:0] product;

    int total;
    int bad;

    mult_seq dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .product (product)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // poke > 0: pulse start with a=2,b=2 during that RUN cycle.
    task automatic op(input string tag, input logic [15:0] ia,
                      input logic [15:0] ib, input logic [31:0] exp,
                      input int poke);
        int nbusy;
        int nd;
        bit seen;
        @(negedge clk);
        a = ia;
        b = ib;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        nbusy = busy ? 1 : 0;
        seen = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (poke > 0 && nbusy == poke) begin
                start = 1'b1;
                a = 16'd2;
                b = 16'd2;
            end
            if (poke > 0 && k > 0 && nbusy == poke + 1) begin
                start = 1'b0;
            end
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                break;
            end
            if (busy) nbusy++;
            if (nbusy == poke + 1 && start) start = 1'b0;
        end
        start = 1'b0;
        chk({tag, "_done"}, 32'(seen), 32'd1);
        chk({tag, "_busy_cycles"}, 32'(nbusy), 32'd16);
        chk({tag, "_product"}, product, exp);
        chk({tag, "_busy_at_done"}, 32'(busy), 32'd0);
        nd = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (done) nd++;
            chk({tag, "_idle_busy"}, 32'(busy), 32'd0);
        end
        chk({tag, "_single_done"}, 32'(nd), 32'd0);
        chk({tag, "_product_hold"}, product, exp);
    endtask

    initial begin
        int last_done;
        int ndone;
        int gap_bad;
        total = 0;
        bad = 0;
        rst = 1'b1;
        start = 1'b0;
        a = '0;
        b = '0;
        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_product", product, 32'd0);
        rst = 1'b0;

        op("3x5", 16'd3, 16'd5, 32'h0000000F, 0);
        op("ffffxffff", 16'hFFFF, 16'hFFFF, 32'hFFFE0001, 0);
        op("1234x0", 16'h1234, 16'h0000, 32'h0, 0);
        op("0x8000", 16'h0000, 16'h8000, 32'h0, 0);
        op("8000x8000", 16'h8000, 16'h8000, 32'h40000000, 0);
        op("7x9_poke", 16'd7, 16'd9, 32'd63, 5);

        // Continuous start: done should recur every 17 cycles.
        @(negedge clk);
        a = 16'd10;
        b = 16'd10;
        start = 1'b1;
        last_done = -1;
        ndone = 0;
        gap_bad = 0;
        for (int k = 0; k < 80 && ndone < 3; k++) begin
            @(negedge clk);
            if (done) begin
                chk("cont_product", product, 32'd100);
                if (last_done >= 0) chk("cont_gap", 32'(k - last_done), 32'd17);
                last_done = k;
                ndone++;
            end
        end
        start = 1'b0;
        chk("cont_count", 32'(ndone), 32'd3);
        @(negedge clk);
        chk("cont_stop_busy", 32'(busy), 32'd0);

        // Reset in the middle of a run.
        a = 16'd100;
        b = 16'd200;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (7) @(negedge clk);
        chk("mid_busy_before", 32'(busy), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_done", 32'(done), 32'd0);
        chk("mid_rst_product", product, 32'd0);
        ndone = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (done || busy) ndone++;
        end
        chk("mid_no_done", 32'(ndone), 32'd0);
        op("2x3", 16'd2, 16'd3, 32'd6, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
